// File: rtl/cpsr_update_ctrl.sv
// CPSR update arbiter: grants one of exception entry, exception return, MSR
// write or ALU flag update per cycle and sequences the two-step exception entry.
module cpsr_update_ctrl #(
    parameter logic [31:0] RESET_VAL = 32'h000000D3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_req,
    input  logic [3:0]  alu_flags,
    input  logic        msr_req,
    input  logic [31:0] msr_data,
    input  logic [3:0]  msr_mask,
    input  logic        exc_req,
    input  logic [4:0]  exc_mode,
    input  logic        ret_req,
    input  logic [31:0] spsr_in,
    output logic        alu_ack,
    output logic        msr_ack,
    output logic        exc_ack,
    output logic        ret_ack,
    output logic [2:0]  CPSR_sel,
    output logic [31:0] cpsr_q,
    output logic        spsr_we,
    output logic [31:0] spsr_out,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: each *_req is a level held by its requester; the matching
    // *_ack is a combinational one-cycle pulse in the cycle the request is
    // granted. A request still high after its ack is treated as a new one.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXC_SAVE  = 2'd1,
        EXC_WRITE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_ALU  = 3'b001;
    localparam logic [2:0] SEL_MSR  = 3'b010;
    localparam logic [2:0] SEL_SPSR = 3'b011;
    localparam logic [2:0] SEL_EXC  = 3'b100;

    state_t      state, next_state;
    logic [31:0] cpsr_d;
    logic [4:0]  mode_q, mode_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cpsr_q <= RESET_VAL;
            mode_q <= 5'd0;
        end else begin
            state  <= next_state;
            cpsr_q <= cpsr_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        next_state = state;
        cpsr_d     = cpsr_q;
        mode_d     = mode_q;
        alu_ack    = 1'b0;
        msr_ack    = 1'b0;
        exc_ack    = 1'b0;
        ret_ack    = 1'b0;
        CPSR_sel   = SEL_HOLD;
        spsr_we    = 1'b0;
        spsr_out   = 32'd0;
        // Grants are suppressed while reset is asserted so acks stay low
        // even though the state is already IDLE.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (exc_req) begin
                        exc_ack    = 1'b1;
                        mode_d     = exc_mode;
                        next_state = EXC_SAVE;
                    end else if (ret_req) begin
                        ret_ack  = 1'b1;
                        CPSR_sel = SEL_SPSR;
                        cpsr_d   = spsr_in;
                    end else if (msr_req) begin
                        msr_ack  = 1'b1;
                        CPSR_sel = SEL_MSR;
                        for (int i = 0; i < 4; i++) begin
                            if (msr_mask[i]) cpsr_d[i*8 +: 8] = msr_data[i*8 +: 8];
                        end
                    end else if (alu_req) begin
                        alu_ack      = 1'b1;
                        CPSR_sel     = SEL_ALU;
                        cpsr_d[31:28] = alu_flags;
                    end
                end
                EXC_SAVE: begin
                    spsr_we    = 1'b1;
                    spsr_out   = cpsr_q;
                    next_state = EXC_WRITE;
                end
                EXC_WRITE: begin
                    // Set I, keep F, clear T, enter the mode latched at grant.
                    CPSR_sel   = SEL_EXC;
                    cpsr_d     = {cpsr_q[31:8], 1'b1, cpsr_q[6], 1'b0, mode_q};
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_cpsr_update_ctrl.sv
// Directed bench for cpsr_update_ctrl: inputs change 1ns after the rising edge,
// combinational outputs are checked on the falling edge, registers after the edge.
module tb_cpsr_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_req, msr_req, exc_req, ret_req;
    logic [3:0]  alu_flags, msr_mask;
    logic [31:0] msr_data, spsr_in;
    logic [4:0]  exc_mode;
    logic        alu_ack, msr_ack, exc_ack, ret_ack;
    logic [2:0]  CPSR_sel;
    logic [31:0] cpsr_q, spsr_out;
    logic        spsr_we, busy;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    cpsr_update_ctrl #(.RESET_VAL(32'h000000D3)) dut (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_flags(alu_flags),
        .msr_req(msr_req), .msr_data(msr_data), .msr_mask(msr_mask),
        .exc_req(exc_req), .exc_mode(exc_mode),
        .ret_req(ret_req), .spsr_in(spsr_in),
        .alu_ack(alu_ack), .msr_ack(msr_ack), .exc_ack(exc_ack), .ret_ack(ret_ack),
        .CPSR_sel(CPSR_sel), .cpsr_q(cpsr_q), .spsr_we(spsr_we), .spsr_out(spsr_out),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Bundled strobe snapshot: {exc,ret,msr,alu ack, sel[2:0], spsr_we, busy}
    function automatic logic [8:0] strobes();
        return {exc_ack, ret_ack, msr_ack, alu_ack, CPSR_sel, spsr_we, busy};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        alu_req = 0; msr_req = 0; exc_req = 0; ret_req = 0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_req = 1; alu_flags = 4'hF; msr_req = 1; msr_data = 0; msr_mask = 4'hF;
        exc_req = 1; exc_mode = 5'b10010; ret_req = 1; spsr_in = 32'h12345678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk32("reset_cpsr", cpsr_q, 32'h000000D3);
        checks++;
        if (strobes() !== 9'd0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=%b", strobes(), 9'd0);
        end
        chk32("reset_spsr_out", spsr_out, 32'd0);
        alu_req = 0; msr_req = 0; exc_req = 0; ret_req = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_alu();
        // First edge after reset release grants the ALU update.
        alu_req = 1; alu_flags = 4'b1010;
        @(negedge clk);
        chk32("alu_strobes", 32'(strobes()), 32'({4'b0001, 3'b001, 1'b0, 1'b0}));
        chk32("alu_cpsr_before", cpsr_q, 32'h000000D3);
        tick();
        alu_req = 0;
        chk32("alu_cpsr_after", cpsr_q, 32'hA00000D3);
        @(negedge clk);
        chk32("idle_strobes", 32'(strobes()), 32'd0);
        tick();
        chk32("idle_cpsr_hold", cpsr_q, 32'hA00000D3);
    endtask

    task automatic test_msr();
        do_reset();
        msr_req = 1; msr_data = 32'hF000001F; msr_mask = 4'b0001;
        @(negedge clk);
        chk32("msr0_strobes", 32'(strobes()), 32'({4'b0010, 3'b010, 1'b0, 1'b0}));
        tick();
        chk32("msr0_cpsr", cpsr_q, 32'h0000001F);
        msr_mask = 4'b1000;  // held level: granted again
        @(negedge clk);
        chk32("msr1_ack", 32'(msr_ack), 32'd1);
        tick();
        chk32("msr1_cpsr", cpsr_q, 32'hF000001F);
        msr_mask = 4'b0000; msr_data = 32'h12345678;
        @(negedge clk);
        chk32("msr2_ack", 32'(msr_ack), 32'd1);
        tick();
        chk32("msr2_cpsr", cpsr_q, 32'hF000001F);
        msr_mask = 4'b1001; msr_data = 32'h6000001F;
        tick();
        msr_req = 0;
        chk32("msr3_cpsr", cpsr_q, 32'h6000001F);
    endtask

    task automatic test_exc_with_alu();
        exc_req = 1; exc_mode = 5'b10010; alu_req = 1; alu_flags = 4'b1111;
        @(negedge clk);
        chk32("exc_grant_strobes", 32'(strobes()), 32'({4'b1000, 3'b000, 1'b0, 1'b0}));
        tick();
        exc_req = 0;
        chk32("exc_grant_cpsr", cpsr_q, 32'h6000001F);
        @(negedge clk);
        chk32("exc_save_strobes", 32'(strobes()), 32'({4'b0000, 3'b000, 1'b1, 1'b1}));
        chk32("exc_save_spsr_out", spsr_out, 32'h6000001F);
        tick();
        chk32("exc_save_cpsr", cpsr_q, 32'h6000001F);
        @(negedge clk);
        chk32("exc_write_strobes", 32'(strobes()), 32'({4'b0000, 3'b100, 1'b0, 1'b1}));
        tick();
        chk32("exc_new_cpsr", cpsr_q, 32'h60000092);
        @(negedge clk);
        chk32("exc_alu_after_strobes", 32'(strobes()), 32'({4'b0001, 3'b001, 1'b0, 1'b0}));
        tick();
        alu_req = 0;
        chk32("exc_alu_after_cpsr", cpsr_q, 32'hF0000092);
    endtask

    task automatic test_ret_msr();
        ret_req = 1; spsr_in = 32'h80000010;
        msr_req = 1; msr_mask = 4'b0001; msr_data = 32'h000000AA;
        @(negedge clk);
        chk32("ret_strobes", 32'(strobes()), 32'({4'b0100, 3'b011, 1'b0, 1'b0}));
        tick();
        ret_req = 0;
        chk32("ret_cpsr", cpsr_q, 32'h80000010);
        @(negedge clk);
        chk32("ret_msr_strobes", 32'(strobes()), 32'({4'b0010, 3'b010, 1'b0, 1'b0}));
        tick();
        msr_req = 0;
        chk32("ret_msr_cpsr", cpsr_q, 32'h800000AA);
    endtask

    task automatic test_reset_mid_exc();
        exc_req = 1; exc_mode = 5'b10011;
        @(negedge clk);
        chk32("abort_grant_ack", 32'(exc_ack), 32'd1);
        tick();
        exc_req = 0;
        #1;
        chk32("abort_in_save_we", 32'(spsr_we), 32'd1);
        reset = 1'b1;
        #1;
        chk32("abort_cpsr", cpsr_q, 32'h000000D3);
        chk32("abort_busy_we", {busy, spsr_we}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk32("abort_we_in_reset", 32'(spsr_we), 32'd0);
        end
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk32("abort_after_strobes", 32'(strobes()), 32'd0);
        end
        tick();
        chk32("abort_after_cpsr", cpsr_q, 32'h000000D3);
    endtask

    task automatic test_mode_latch();
        exc_req = 1; exc_mode = 5'b10001;
        @(negedge clk);
        chk32("latch_ack", 32'(exc_ack), 32'd1);
        tick();
        exc_req = 0; exc_mode = 5'b10111;
        @(negedge clk);
        chk32("latch_save_we", 32'(spsr_we), 32'd1);
        chk32("latch_save_spsr_out", spsr_out, 32'h000000D3);
        tick();
        chk32("latch_cpsr_unchanged", cpsr_q, 32'h000000D3);
        tick();
        chk32("latch_cpsr_final", cpsr_q, 32'h000000D1);
        chk32("latch_mode_field", 32'(cpsr_q[4:0]), 32'(5'b10001));
        chk32("latch_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_msr();
        test_exc_with_alu();
        test_ret_msr();
        test_reset_mid_exc();
        test_mode_latch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpsr_update_ctrl.md
CPSR_UPDATE_CTRL -- requirements
Module: cpsr_update_ctrl

Interface
REQ-001 Parameter RESET_VAL, 32'h000000D3, CPSR value loaded on reset (SVC mode, I=1, F=1, T=0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_req  input  1  ALU flag-update request; held until alu_ack.
REQ-005 alu_flags  input  4  new N,Z,C,V.
REQ-006 msr_req  input  1  MSR write request; held until msr_ack.
REQ-007 msr_data  input  32  MSR source operand.
REQ-008 msr_mask  input  4  byte-lane write enables; bit3 = CPSR[31:24], bit0 = CPSR[7:0].
REQ-009 exc_req  input  1  exception entry request; held until exc_ack.
REQ-010 exc_mode  input  5  target mode for exception entry.
REQ-011 ret_req  input  1  exception return request; held until ret_ack.
REQ-012 spsr_in  input  32  SPSR value to restore on return.
REQ-013 alu_ack, msr_ack, exc_ack, ret_ack  output  1 each  one-cycle grant pulses.
REQ-014 CPSR_sel  output  3  source selected this cycle: 000 hold, 001 ALU, 010 MSR, 011 SPSR restore, 100 exception entry.
REQ-015 cpsr_q  output  32  current CPSR register.
REQ-016 spsr_we  output  1  one-cycle SPSR write strobe.
REQ-017 spsr_out  output  32  value to write to SPSR; valid while spsr_we=1.
REQ-018 busy  output  1  high while the exception-entry sequence is in progress.

Function
REQ-019 States: IDLE, EXC_SAVE, EXC_WRITE; the block SHALL leave IDLE only on a granted exc_req.
REQ-020 In IDLE, fixed priority SHALL be exc_req > ret_req > msr_req > alu_req; at most one request is granted per cycle.
REQ-021 ALU grant: cpsr_q[31:28] <= alu_flags, other bits held; CPSR_sel=001; alu_ack=1 in the same cycle; new value visible the next cycle.
REQ-022 MSR grant: each byte lane with msr_mask bit=1 takes msr_data, other lanes held; CPSR_sel=010; msr_ack=1; mask 0000 still acks and leaves cpsr_q unchanged.
REQ-023 Return grant: cpsr_q <= spsr_in; CPSR_sel=011; ret_ack=1.
REQ-024 Exception grant in IDLE: exc_ack=1, go to EXC_SAVE; cpsr_q is unchanged that cycle; CPSR_sel=000.
REQ-025 EXC_SAVE: spsr_we=1, spsr_out = cpsr_q; busy=1; CPSR_sel=000; go to EXC_WRITE.
REQ-026 EXC_WRITE: cpsr_q <= {cpsr_q[31:8], 1'b1, cpsr_q[6], 1'b0, latched exc_mode}; CPSR_sel=100; busy=1; return to IDLE.
REQ-027 exc_mode SHALL be latched at exception grant; later changes have no effect on the sequence.
REQ-028 While busy, no request SHALL be granted; held requests are serviced in priority order after return to IDLE.
REQ-029 Ungranted requests SHALL receive no ack and SHALL not change cpsr_q.
REQ-030 With no grant and not in EXC_WRITE, CPSR_sel=000 and cpsr_q holds.
REQ-031 A requester that holds its request after its ack SHALL be granted again: a held level is a new request.
REQ-032 spsr_we SHALL be 0 in every state except EXC_SAVE.
REQ-033 Exception entry latency: exc_req at IDLE in cycle N gives spsr_we in cycle N+1 and new cpsr_q visible from cycle N+3.

Reset
REQ-034 On reset assertion, without waiting for clk: state=IDLE, cpsr_q=RESET_VAL, all acks=0, spsr_we=0, spsr_out=0, busy=0, CPSR_sel=000.
REQ-035 Reset asserted mid-exception-sequence SHALL abort it; no spsr_we occurs after reset asserts.
REQ-036 The first grant SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-037 Reset release, alu_req=1, alu_flags=4'b1010 -> alu_ack pulse; CPSR_sel=001; cpsr_q=32'hA00000D3 next cycle.
REQ-038 msr_req with msr_data=32'hF00000 1F and msr_mask=4'b0001 from reset -> cpsr_q=32'h0000001F; msr_mask=4'b1000 -> only [31:24] change to 8'hF0.
REQ-039 exc_req, exc_mode=5'b10010, and alu_req asserted together with cpsr_q=32'h6000001F -> exc_ack; spsr_we with spsr_out=32'h6000001F; then cpsr_q=32'h60000092; alu_ack only after busy falls.
REQ-040 ret_req and msr_req asserted together, spsr_in=32'h80000010 -> ret_ack only; cpsr_q=32'h80000010; msr_ack the following cycle.
REQ-041 Reset asserted in EXC_SAVE -> cpsr_q=32'h000000D3 immediately; busy=0; no further spsr_we.
REQ-042 exc_mode changed to 5'b10111 during EXC_SAVE after granting with 5'b10001 -> final mode field = 5'b10001.
